// File: rtl/hv_bundler_if.sv
// rtl/hv_bundler_if.sv - hypervector streams into and out of the bundling stage
//
// Purpose: groups the bound-vector input stream and the encoded-vector
//          output handshake of hv_bundler into one bundle.
// Signals:
//   bound_valid   bound_hv carries a vector this cycle
//   bound_hv      bound (sparse) hypervector to accumulate
//   hv_out        thresholded encoded hypervector
//   hv_out_valid  hv_out is valid
//   hv_out_ready  downstream accepts hv_out
// Modports: slave = bundler side, master = encoder/classifier side.

interface hv_bundler_if #(
  parameter int DIM = 512
);
  logic           bound_valid;
  logic [DIM-1:0] bound_hv;
  logic [DIM-1:0] hv_out;
  logic           hv_out_valid;
  logic           hv_out_ready;

  modport master (
    output bound_valid, bound_hv, hv_out_ready,
    input  hv_out, hv_out_valid
  );

  modport slave (
    input  bound_valid, bound_hv, hv_out_ready,
    output hv_out, hv_out_valid
  );
endinterface

// File: rtl/hv_bundler.sv
// rtl/hv_bundler.sv - per-dimension vote bundling and thresholding of bound hypervectors
//
// Purpose: accumulates bound hypervectors into saturating per-dimension
//          counters between start_binding and encoding_done, thresholds them
//          into hv_out and presents it over a valid/ready handshake.
// Ports:
//   clk            single clock, rising edge
//   nrst           synchronous active-high reset
//   en             global enable; 0 freezes everything
//   start_binding  opens a new bundle (one-cycle pulse)
//   encoding_done  closes the bundle (one-cycle pulse)
//   bus            hv_bundler_if.slave: bound_* input stream, hv_out* output handshake
//   n_accum        vectors accumulated in the current or last bundle
//   busy           state != IDLE
//   err            sticky protocol-error flag

module hv_bundler #(
  parameter int DIM             = 512,
  parameter int SEQ_CYCLE_COUNT = 16,
  parameter int CNT_W           = $clog2(SEQ_CYCLE_COUNT + 1),
  parameter int THRESHOLD       = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             start_binding,
  input  logic             encoding_done,
  hv_bundler_if.slave      bus,
  output logic [CNT_W-1:0] n_accum,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, OUT} state_t;

  localparam logic [CNT_W-1:0] SAT = CNT_W'(SEQ_CYCLE_COUNT);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic             clr, acc, thr, xfer, err_set;
  logic [CNT_W-1:0] cnt [DIM];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    acc       = 1'b0;
    thr       = 1'b0;
    xfer      = 1'b0;
    err_set   = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (start_binding) begin
            state_nxt = ACCUM;
            clr       = 1'b1;
          end
        end
        ACCUM: begin
          // A restart discards the bundle and anything arriving with it.
          if (start_binding) begin
            clr     = 1'b1;
            err_set = 1'b1;
          end else begin
            if (bus.bound_valid) begin
              if (n_accum == SAT) err_set = 1'b1;
              else                acc     = 1'b1;
            end
            if (encoding_done) state_nxt = THRESH;
          end
        end
        THRESH: begin
          thr       = 1'b1;
          state_nxt = OUT;
          if (start_binding) err_set = 1'b1;
        end
        OUT: begin
          if (bus.hv_out_valid && bus.hv_out_ready) begin
            xfer = 1'b1;
            // Transfer plus start opens the next bundle with no idle bubble.
            if (start_binding) begin
              state_nxt = ACCUM;
              clr       = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else if (start_binding) begin
            err_set = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < DIM; i++) cnt[i] <= '0;
      n_accum          <= '0;
      bus.hv_out       <= '0;
      bus.hv_out_valid <= 1'b0;
      err              <= 1'b0;
    end else begin
      if (clr) begin
        for (int i = 0; i < DIM; i++) cnt[i] <= '0;
        n_accum <= '0;
      end else if (acc) begin
        for (int i = 0; i < DIM; i++) begin
          if (bus.bound_hv[i] && (cnt[i] != SAT)) cnt[i] <= cnt[i] + ONE;
        end
        n_accum <= n_accum + ONE;
      end
      if (thr) begin
        for (int i = 0; i < DIM; i++) bus.hv_out[i] <= (cnt[i] >= THR);
        bus.hv_out_valid <= 1'b1;
      end else if (xfer) begin
        bus.hv_out_valid <= 1'b0;
      end
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: doc/hv_bundler.md
# hv_bundler

Bundling stage directly downstream of the encoding control FSM. It consumes the bound hypervectors produced while the FSM sits in its bundle phase and keeps one saturating vote counter per dimension. When the FSM signals `encoding_done`, it thresholds the counters into a sparse encoded hypervector. The result is handed to the classifier/associative-memory stage over a valid/ready handshake.

## Interface
- `DIM`, 512: hypervector width in bits.
- `SEQ_CYCLE_COUNT`, 16: bound vectors bundled per encoding. Same value the control FSM uses.
- `CNT_W`, $clog2(SEQ_CYCLE_COUNT+1): per-dimension counter width.
- `THRESHOLD`, 4: output bit i = 1 iff count[i] >= THRESHOLD. Legal range 1..SEQ_CYCLE_COUNT.

- `clk`  in  1  single clock. All state updates on the rising edge.
- `nrst`  in  1  reset, synchronous and active-high. When `nrst`=1 at a rising `clk` edge, the block resets.
- `en`  in  1  global enable, shared with the control FSM.
- `start_binding`  in  1  one-cycle pulse from the FSM. Opens a new bundle.
- `encoding_done`  in  1  one-cycle pulse from the FSM. Closes the bundle.
- `bound_valid`  in  1  `bound_hv` carries a vector this cycle.
- `bound_hv`  in  DIM  bound (sparse) hypervector to accumulate.
- `hv_out`  out  DIM  thresholded encoded hypervector.
- `hv_out_valid`  out  1  `hv_out` is valid.
- `hv_out_ready`  in  1  downstream accepts `hv_out`.
- `n_accum`  out  CNT_W  number of vectors accumulated in the current or last bundle.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, ACCUM, THRESH, OUT.
- Reset values: state=IDLE, all counters=0, `hv_out`=0, `hv_out_valid`=0, `n_accum`=0, `busy`=0, `err`=0. Reset wins over every other input, including mid-bundle and mid-handshake.
- `en`=0: full freeze. No state change, no accumulation, no handshake transfer. Outputs hold their values.
- All transitions below require `en`=1.
- IDLE:
  - `start_binding` → ACCUM. All counters and `n_accum` clear to 0.
  - `encoding_done` or `bound_valid` → ignored.
- ACCUM, each cycle with `bound_valid`=1:
  - count[i] += `bound_hv`[i], saturating at SEQ_CYCLE_COUNT.
  - `n_accum` += 1.
  - If `n_accum` is already SEQ_CYCLE_COUNT, the vector is dropped and `err` is set.
- ACCUM, `encoding_done`=1 → THRESH.
  - A `bound_valid` in the same cycle is still accumulated.
- ACCUM, `start_binding`=1: counters and `n_accum` clear; state stays ACCUM; `err` is set. Restart semantics; no vector from that cycle is accumulated.
- THRESH (exactly one cycle):
  - `hv_out`[i] <= (count[i] >= THRESHOLD).
  - → OUT, with `hv_out_valid`=1 from the next cycle.
- OUT:
  - `hv_out_valid`=1 and `hv_out` stable until `hv_out_valid && hv_out_ready && en`.
  - On transfer → IDLE and `hv_out_valid` drops the next cycle.
  - A `start_binding` arriving in the same cycle as the transfer goes straight to ACCUM with cleared counters. No bubble.
- `start_binding` in THRESH, or in OUT without a transfer: ignored and `err` is set.
- `err` clears only on reset.
- Counters are unsigned CNT_W bits; comparison is unsigned. An all-zero `hv_out` is legal.

## Timing
- Nominal sequence from the FSM:
  - `start_binding` at cycle t.
  - `bound_valid` in cycles t+1 … t+SEQ_CYCLE_COUNT.
  - `encoding_done` at t+SEQ_CYCLE_COUNT+1.
- Latency: `encoding_done` at cycle e gives THRESH at e+1 and `hv_out_valid`=1 at e+2.
- Throughput: one encoding per SEQ_CYCLE_COUNT+3 cycles when `hv_out_ready` is held high.
- `hv_out` is registered. There is no combinational path from any input to `hv_out` or `hv_out_valid`.
- `hv_out_ready` may be asserted before `hv_out_valid`; no transfer occurs until valid is high.

## Test plan
Bench parameters: DIM=8, SEQ_CYCLE_COUNT=4, THRESHOLD=2.

1. Nominal bundle:
   - Stimulus: reset 2 cycles; `start_binding`; `bound_hv`=0x03,0x06,0x0C,0x01; `encoding_done`; `hv_out_ready`=1.
   - Response: `hv_out_valid` 2 cycles after `encoding_done`; `hv_out`=0x07; `n_accum`=4; `err`=0.
2. Backpressure:
   - Stimulus: as scenario 1 with `hv_out_ready`=0 for 5 cycles.
   - Response: `hv_out`=0x07 and valid held stable all 5 cycles; transfer on the ready cycle; IDLE the next cycle.
3. Overflow:
   - Stimulus: 5 vectors of 0xFF before `encoding_done`.
   - Response: 5th vector dropped; `n_accum`=4; `hv_out`=0xFF; `err`=1.
4. Enable freeze:
   - Stimulus: `en`=0 for 3 cycles mid-ACCUM while `bound_valid`=1.
   - Response: counts and `n_accum` unchanged across those cycles; bundle completes correctly after `en` returns.
5. Reset mid-operation:
   - Stimulus: `nrst`=1 during ACCUM, and separately during OUT.
   - Response: next cycle state=IDLE, `hv_out_valid`=0, `hv_out`=0, `err`=0.
6. Back-to-back:
   - Stimulus: transfer and next `start_binding` in the same cycle; second bundle 0x80×4.
   - Response: ACCUM with cleared counters; second `hv_out`=0x80, unaffected by the first bundle.
